// File: rtl/ex_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_mc
// Description : Execute stage with single-cycle ALU/shifter and an iterative
//               shift-add multiplier that stalls upstream; the output
//               registers form the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_mc #(
   parameter int WIDTH  = 32,
   parameter int SHW    = 5,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             IN_VALID,
   input  logic             FLUSH,
   input  logic [WIDTH-1:0] PC_M2,
   input  logic [WIDTH-1:0] BUS_A,
   input  logic [WIDTH-1:0] BUS_B,
   input  logic [4:0]       FS,
   input  logic [SHW-1:0]   SH,
   input  logic             RW,
   input  logic             PS,
   input  logic             MW,
   input  logic [4:0]       DA,
   input  logic [1:0]       MD,
   input  logic [1:0]       BS,
   output logic             STALL,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] F,
   output logic [WIDTH-1:0] Data_Out,
   output logic [WIDTH-1:0] BrA,
   output logic [WIDTH-1:0] RAA,
   output logic             Z,
   output logic             V,
   output logic             N,
   output logic             C,
   output logic             VxorN,
   output logic             RW_out,
   output logic             PS_out,
   output logic             MW_out,
   output logic [4:0]       DA_out,
   output logic [1:0]       MD_out,
   output logic [1:0]       BS_out
);

   localparam logic [4:0]     c_FS_A    = 5'b00000;
   localparam logic [4:0]     c_FS_ADD  = 5'b00010;
   localparam logic [4:0]     c_FS_SUB  = 5'b00101;
   localparam logic [4:0]     c_FS_B    = 5'b00111;
   localparam logic [4:0]     c_FS_AND  = 5'b01000;
   localparam logic [4:0]     c_FS_OR   = 5'b01010;
   localparam logic [4:0]     c_FS_XOR  = 5'b01100;
   localparam logic [4:0]     c_FS_NOT  = 5'b01110;
   localparam logic [4:0]     c_FS_SRL  = 5'b10000;
   localparam logic [4:0]     c_FS_SLL  = 5'b10001;
   localparam logic [4:0]     c_FS_MUL  = 5'b11000;
   localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t r_state, w_state_nxt;

   // multiplier working registers; operands double as RAA/Data_Out sources
   logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_l_bra;
   logic [SHW-1:0]   r_cnt;
   logic             r_l_rw, r_l_ps, r_l_mw;
   logic [4:0]       r_l_da;
   logic [1:0]       r_l_md, r_l_bs;

   // output register bank
   logic             r_ov, r_z, r_v, r_n, r_c, r_vxn, r_rw, r_ps, r_mw;
   logic [WIDTH-1:0] r_f, r_dout, r_bra, r_raa;
   logic [4:0]       r_da;
   logic [1:0]       r_md, r_bs;

   logic             w_is_mul, w_accept, w_mul_last, w_load, w_cin, w_ovf;
   logic [WIDTH-1:0] w_bop, w_mul_add, w_mul_next, w_bra_in;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_f;
   logic             w_alu_c, w_alu_v;
   logic [WIDTH-1:0] w_ld_f, w_ld_dout, w_ld_raa, w_ld_bra;
   logic             w_ld_c, w_ld_v, w_ld_rw, w_ld_ps, w_ld_mw;
   logic [4:0]       w_ld_da;
   logic [1:0]       w_ld_md, w_ld_bs;

   assign STALL      = (r_state == S_MUL);
   assign w_is_mul   = MUL_EN && (FS == c_FS_MUL);
   assign w_accept   = IN_VALID && !FLUSH && (r_state == S_IDLE);
   assign w_mul_last = (r_cnt == c_CNT_LAST);
   assign w_load     = (w_accept && !w_is_mul) ||
                       ((r_state == S_MUL) && !FLUSH && w_mul_last);
   assign w_bra_in   = PC_M2 + BUS_B;

   // shared adder: subtraction is A + ~B + 1 so carry means "no borrow"
   assign w_cin = (FS == c_FS_SUB);
   assign w_bop = w_cin ? ~BUS_B : BUS_B;
   assign w_sum = {1'b0, BUS_A} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
   assign w_ovf = (BUS_A[WIDTH-1] == w_bop[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != BUS_A[WIDTH-1]);

   // one shift-add iteration: add multiplicand<<cnt when multiplier bit cnt is set
   assign w_mul_add  = r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0;
   assign w_mul_next = r_acc + w_mul_add;

   // single-cycle function decode; MUL (when enabled) bypasses this path
   always_comb begin
      w_alu_f = '0;
      w_alu_c = 1'b0;
      w_alu_v = 1'b0;
      case (FS)
         c_FS_A:   w_alu_f = BUS_A;
         c_FS_ADD, c_FS_SUB: begin
            w_alu_f = w_sum[WIDTH-1:0];
            w_alu_c = w_sum[WIDTH];
            w_alu_v = w_ovf;
         end
         c_FS_B:   w_alu_f = BUS_B;
         c_FS_AND: w_alu_f = BUS_A & BUS_B;
         c_FS_OR:  w_alu_f = BUS_A | BUS_B;
         c_FS_XOR: w_alu_f = BUS_A ^ BUS_B;
         c_FS_NOT: w_alu_f = ~BUS_A;
         c_FS_SRL: w_alu_f = BUS_A >> SH;
         c_FS_SLL: w_alu_f = BUS_A << SH;
         default:  w_alu_f = '0;
      endcase
   end

   // select what the output register captures: finishing MUL or live inputs
   always_comb begin
      w_ld_f    = w_alu_f;
      w_ld_c    = w_alu_c;
      w_ld_v    = w_alu_v;
      w_ld_dout = BUS_B;
      w_ld_raa  = BUS_A;
      w_ld_bra  = w_bra_in;
      w_ld_rw   = RW;
      w_ld_ps   = PS;
      w_ld_mw   = MW;
      w_ld_da   = DA;
      w_ld_md   = MD;
      w_ld_bs   = BS;
      if (r_state == S_MUL) begin
         w_ld_f    = w_mul_next;
         w_ld_c    = 1'b0;
         w_ld_v    = 1'b0;
         w_ld_dout = r_mplier;
         w_ld_raa  = r_mcand;
         w_ld_bra  = r_l_bra;
         w_ld_rw   = r_l_rw;
         w_ld_ps   = r_l_ps;
         w_ld_mw   = r_l_mw;
         w_ld_da   = r_l_da;
         w_ld_md   = r_l_md;
         w_ld_bs   = r_l_bs;
      end
   end

   // FSM state register
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: flush always returns to idle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
         S_MUL:   if (FLUSH || w_mul_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // multiplier operand capture and iteration
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_l_bra  <= '0;
         r_l_rw   <= 1'b0;
         r_l_ps   <= 1'b0;
         r_l_mw   <= 1'b0;
         r_l_da   <= '0;
         r_l_md   <= '0;
         r_l_bs   <= '0;
      end else if (FLUSH) begin
         r_cnt <= '0;
      end else if (w_accept && w_is_mul) begin
         r_mcand  <= BUS_A;
         r_mplier <= BUS_B;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_l_bra  <= w_bra_in;
         r_l_rw   <= RW;
         r_l_ps   <= PS;
         r_l_mw   <= MW;
         r_l_da   <= DA;
         r_l_md   <= MD;
         r_l_bs   <= BS;
      end else if (r_state == S_MUL) begin
         r_acc <= w_mul_next;
         r_cnt <= r_cnt + SHW'(1);
      end
   end

   // EX/MEM register: load on completion, otherwise insert a safe bubble
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_ov   <= 1'b0;
         r_f    <= '0;
         r_dout <= '0;
         r_bra  <= '0;
         r_raa  <= '0;
         r_z    <= 1'b0;
         r_v    <= 1'b0;
         r_n    <= 1'b0;
         r_c    <= 1'b0;
         r_vxn  <= 1'b0;
         r_rw   <= 1'b0;
         r_ps   <= 1'b0;
         r_mw   <= 1'b0;
         r_da   <= '0;
         r_md   <= '0;
         r_bs   <= '0;
      end else if (w_load) begin
         r_ov   <= 1'b1;
         r_f    <= w_ld_f;
         r_dout <= w_ld_dout;
         r_bra  <= w_ld_bra;
         r_raa  <= w_ld_raa;
         r_z    <= (w_ld_f == '0);
         r_v    <= w_ld_v;
         r_n    <= w_ld_f[WIDTH-1];
         r_c    <= w_ld_c;
         r_vxn  <= w_ld_v ^ w_ld_f[WIDTH-1];
         r_rw   <= w_ld_rw;
         r_ps   <= w_ld_ps;
         r_mw   <= w_ld_mw;
         r_da   <= w_ld_da;
         r_md   <= w_ld_md;
         r_bs   <= w_ld_bs;
      end else begin
         r_ov <= 1'b0;
         r_rw <= 1'b0;
         r_mw <= 1'b0;
      end
   end

   assign OUT_VALID = r_ov;
   assign F         = r_f;
   assign Data_Out  = r_dout;
   assign BrA       = r_bra;
   assign RAA       = r_raa;
   assign Z         = r_z;
   assign V         = r_v;
   assign N         = r_n;
   assign C         = r_c;
   assign VxorN     = r_vxn;
   assign RW_out    = r_rw;
   assign PS_out    = r_ps;
   assign MW_out    = r_mw;
   assign DA_out    = r_da;
   assign MD_out    = r_md;
   assign BS_out    = r_bs;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_mc
// Description : Self-checking bench for ex_stage_mc (MUL enabled and disabled
//               builds) against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_mc;

   localparam int WIDTH = 32;
   localparam longint c_SMAX = 64'sd2147483647;
   localparam longint c_SMIN = -64'sd2147483648;

   typedef struct packed {
      logic        ov;
      logic [31:0] f, dout, bra, raa;
      logic        z, v, n, c, vxn, rw, ps, mw;
      logic [4:0]  da;
      logic [1:0]  md, bs;
   } out_t;

   typedef struct packed {
      logic        valid, flush;
      logic [31:0] pc, a, b;
      logic [4:0]  fs, sh;
      logic        rw, ps, mw;
      logic [4:0]  da;
      logic [1:0]  md, bs;
   } in_t;

   logic CLOCK = 1'b0;
   logic RESET, IN_VALID, FLUSH, RW, PS, MW;
   logic [31:0] PC_M2, BUS_A, BUS_B;
   logic [4:0]  FS, SH, DA;
   logic [1:0]  MD, BS;

   logic STALL, OUT_VALID, Z, V, N, C, VxorN, RW_out, PS_out, MW_out;
   logic [31:0] F, Data_Out, BrA, RAA;
   logic [4:0]  DA_out;
   logic [1:0]  MD_out, BS_out;

   logic STALL_2, OUT_VALID_2, Z_2, V_2, N_2, C_2, VxorN_2, RW_out_2, PS_out_2, MW_out_2;
   logic [31:0] F_2, Data_Out_2, BrA_2, RAA_2;
   logic [4:0]  DA_out_2;
   logic [1:0]  MD_out_2, BS_out_2;

   int   n_cmp = 0;
   int   n_bad = 0;
   out_t m1, m2, obs1, obs2;

   always #5 CLOCK = ~CLOCK;

   ex_stage_mc #(.WIDTH(32), .SHW(5), .MUL_EN(1'b1)) u_dut (
      .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .FLUSH(FLUSH),
      .PC_M2(PC_M2), .BUS_A(BUS_A), .BUS_B(BUS_B), .FS(FS), .SH(SH),
      .RW(RW), .PS(PS), .MW(MW), .DA(DA), .MD(MD), .BS(BS),
      .STALL(STALL), .OUT_VALID(OUT_VALID), .F(F), .Data_Out(Data_Out),
      .BrA(BrA), .RAA(RAA), .Z(Z), .V(V), .N(N), .C(C), .VxorN(VxorN),
      .RW_out(RW_out), .PS_out(PS_out), .MW_out(MW_out), .DA_out(DA_out),
      .MD_out(MD_out), .BS_out(BS_out));

   ex_stage_mc #(.WIDTH(32), .SHW(5), .MUL_EN(1'b0)) u_dut_nomul (
      .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .FLUSH(FLUSH),
      .PC_M2(PC_M2), .BUS_A(BUS_A), .BUS_B(BUS_B), .FS(FS), .SH(SH),
      .RW(RW), .PS(PS), .MW(MW), .DA(DA), .MD(MD), .BS(BS),
      .STALL(STALL_2), .OUT_VALID(OUT_VALID_2), .F(F_2), .Data_Out(Data_Out_2),
      .BrA(BrA_2), .RAA(RAA_2), .Z(Z_2), .V(V_2), .N(N_2), .C(C_2), .VxorN(VxorN_2),
      .RW_out(RW_out_2), .PS_out(PS_out_2), .MW_out(MW_out_2), .DA_out(DA_out_2),
      .MD_out(MD_out_2), .BS_out(BS_out_2));

   always_comb obs1 = {OUT_VALID, F, Data_Out, BrA, RAA, Z, V, N, C, VxorN,
                       RW_out, PS_out, MW_out, DA_out, MD_out, BS_out};
   always_comb obs2 = {OUT_VALID_2, F_2, Data_Out_2, BrA_2, RAA_2, Z_2, V_2, N_2, C_2, VxorN_2,
                       RW_out_2, PS_out_2, MW_out_2, DA_out_2, MD_out_2, BS_out_2};

   // reference model: architectural result of one completed instruction
   function automatic out_t op_result(in_t x, bit mul_en);
      out_t        o;
      logic [63:0] p;
      logic [32:0] u;
      longint      sa, sb, sr;
      o     = '0;
      o.ov  = 1'b1;
      o.dout = x.b;
      o.raa = x.a;
      o.bra = x.pc + x.b;
      o.rw  = x.rw;  o.ps = x.ps;  o.mw = x.mw;
      o.da  = x.da;  o.md = x.md;  o.bs = x.bs;
      sa = longint'($signed(x.a));
      sb = longint'($signed(x.b));
      case (x.fs)
         5'b00000: o.f = x.a;
         5'b00010: begin
            u   = {1'b0, x.a} + {1'b0, x.b};
            o.f = u[31:0];
            o.c = u[32];
            sr  = sa + sb;
            o.v = (sr > c_SMAX) || (sr < c_SMIN);
         end
         5'b00101: begin
            o.f = x.a - x.b;
            o.c = (x.a >= x.b);
            sr  = sa - sb;
            o.v = (sr > c_SMAX) || (sr < c_SMIN);
         end
         5'b00111: o.f = x.b;
         5'b01000: o.f = x.a & x.b;
         5'b01010: o.f = x.a | x.b;
         5'b01100: o.f = x.a ^ x.b;
         5'b01110: o.f = ~x.a;
         5'b10000: o.f = x.a >> x.sh;
         5'b10001: o.f = x.a << x.sh;
         5'b11000: begin
            p   = 64'(x.a) * 64'(x.b);
            o.f = mul_en ? p[31:0] : 32'h0;
         end
         default:  o.f = '0;
      endcase
      o.z   = (o.f == 32'h0);
      o.n   = o.f[31];
      o.vxn = o.v ^ o.n;
      return o;
   endfunction

   function automatic out_t bubble(out_t o);
      out_t r;
      r    = o;
      r.ov = 1'b0;
      r.rw = 1'b0;
      r.mw = 1'b0;
      return r;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   function automatic in_t rand_in(bit allow_mul);
      in_t x;
      x.valid = ($urandom_range(0, 9) != 0);
      x.flush = 1'b0;
      x.pc    = $urandom;
      x.a     = pick_val();
      x.b     = ($urandom_range(0, 5) == 0) ? x.a : pick_val();
      x.sh    = 5'($urandom);
      x.rw    = 1'($urandom);
      x.ps    = 1'($urandom);
      x.mw    = 1'($urandom);
      x.da    = 5'($urandom);
      x.md    = 2'($urandom);
      x.bs    = 2'($urandom);
      do begin
         case ($urandom_range(0, 11))
            0:  x.fs = 5'b00000;  1:  x.fs = 5'b00010;  2:  x.fs = 5'b00101;
            3:  x.fs = 5'b00111;  4:  x.fs = 5'b01000;  5:  x.fs = 5'b01010;
            6:  x.fs = 5'b01100;  7:  x.fs = 5'b01110;  8:  x.fs = 5'b10000;
            9:  x.fs = 5'b10001;  10: x.fs = 5'b11000;
            default: x.fs = 5'($urandom);
         endcase
      end while (!allow_mul && x.fs == 5'b11000);
      return x;
   endfunction

   function automatic in_t idle_in();
      in_t x;
      x = '0;
      return x;
   endfunction

   task automatic drive(input in_t x);
      IN_VALID = x.valid; FLUSH = x.flush; PC_M2 = x.pc; BUS_A = x.a; BUS_B = x.b;
      FS = x.fs; SH = x.sh; RW = x.rw; PS = x.ps; MW = x.mw; DA = x.da; MD = x.md; BS = x.bs;
   endtask

   // apply inputs for one rising edge, return at the following falling edge
   task automatic step(input in_t x);
      drive(x);
      @(posedge CLOCK);
      @(negedge CLOCK);
      if (x.valid && !x.flush) m2 = op_result(x, 1'b0);
      else                     m2 = bubble(m2);
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      drive(idle_in());
      #3;
      n_cmp++;
      if ({obs1, STALL} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got %h stall=%b, want all zero", obs1, STALL);
      end
      n_cmp++;
      if ({obs2, STALL_2} !== '0) begin
         n_bad++;
         $display("FAIL reset_state_nomul: got %h stall=%b, want all zero", obs2, STALL_2);
      end
      @(negedge CLOCK);
      RESET = 1'b1;
      m1 = '0;
      m2 = '0;
   endtask

   task automatic test_directed();
      in_t x;
      x = idle_in(); x.valid = 1'b1; x.a = 32'd8; x.b = 32'd8; x.fs = 5'b00010; x.rw = 1'b1;
      step(x); m1 = op_result(x, 1'b1);
      n_cmp++;
      if ({OUT_VALID, F, Z, C, V} !== {1'b1, 32'h10, 1'b0, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL add_8_8: got ov=%b F=%h Z=%b C=%b V=%b, want ov=1 F=10 Z=0 C=0 V=0",
                  OUT_VALID, F, Z, C, V);
      end
      x.fs = 5'b00101;
      step(x); m1 = op_result(x, 1'b1);
      n_cmp++;
      if ({F, Z, C, N} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL sub_8_8: got F=%h Z=%b C=%b N=%b, want F=0 Z=1 C=1 N=0", F, Z, C, N);
      end
      x.a = 32'h7FFF_FFFF; x.b = 32'd1; x.fs = 5'b00010;
      step(x); m1 = op_result(x, 1'b1);
      n_cmp++;
      if ({F, V, N, VxorN} !== {32'h8000_0000, 1'b1, 1'b1, 1'b0}) begin
         n_bad++;
         $display("FAIL add_overflow: got F=%h V=%b N=%b VxorN=%b, want F=80000000 V=1 N=1 VxorN=0",
                  F, V, N, VxorN);
      end
      x.a = 32'd8; x.sh = 5'd4; x.fs = 5'b10001;
      step(x); m1 = op_result(x, 1'b1);
      n_cmp++;
      if (F !== 32'h80) begin
         n_bad++;
         $display("FAIL sll_8_4: got F=%h, want 80", F);
      end
      x.fs = 5'b10000;
      step(x); m1 = op_result(x, 1'b1);
      n_cmp++;
      if (F !== 32'h0) begin
         n_bad++;
         $display("FAIL srl_8_4: got F=%h, want 0", F);
      end
      x.pc = 32'd1; x.b = 32'd8; x.fs = 5'b00000;
      step(x); m1 = op_result(x, 1'b1);
      n_cmp++;
      if ({BrA, RAA, Data_Out} !== {32'd9, 32'd8, 32'd8}) begin
         n_bad++;
         $display("FAIL branch_target: got BrA=%h RAA=%h Data_Out=%h, want 9 8 8", BrA, RAA, Data_Out);
      end
      step(idle_in()); m1 = bubble(m1);
      n_cmp++;
      if (obs1 !== m1) begin
         n_bad++;
         $display("FAIL bubble_hold: got %h, want %h", obs1, m1);
      end
   endtask

   task automatic test_random_alu();
      in_t x;
      for (int i = 0; i < 150; i++) begin
         x = rand_in(1'b0);
         step(x);
         m1 = x.valid ? op_result(x, 1'b1) : bubble(m1);
         n_cmp++;
         if ({obs1, STALL} !== {m1, 1'b0}) begin
            n_bad++;
            $display("FAIL random_alu[%0d] fs=%b: got %h stall=%b, want %h", i, x.fs, obs1, STALL, m1);
         end
         n_cmp++;
         if (obs2 !== m2) begin
            n_bad++;
            $display("FAIL random_alu_nomul[%0d]: got %h, want %h", i, obs2, m2);
         end
      end
   endtask

   // one MUL with junk inputs during the stall and an ADD waiting behind it
   task automatic test_mul_case(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] f_res, output logic [2:0] ncv_res);
      in_t mi, held, junk;
      int  stall_cnt, ov_cnt;
      mi = rand_in(1'b0); mi.valid = 1'b1; mi.fs = 5'b11000; mi.a = a; mi.b = b;
      held = rand_in(1'b0); held.valid = 1'b1; held.fs = 5'b00010;
      stall_cnt = 0;
      ov_cnt = 0;
      step(mi); m1 = bubble(m1);
      for (int k = 1; k <= WIDTH; k++) begin
         stall_cnt += int'(STALL);
         ov_cnt    += int'(OUT_VALID);
         n_cmp++;
         if (obs1 !== m1) begin
            n_bad++;
            $display("FAIL mul_busy[%0d]: got %h, want %h", k, obs1, m1);
         end
         junk = rand_in(1'b1);
         step((k == WIDTH) ? held : junk);
         if (k == WIDTH) m1 = op_result(mi, 1'b1);
      end
      ov_cnt += int'(OUT_VALID);
      f_res   = F;
      ncv_res = {N, C, V};
      n_cmp++;
      if ({obs1, STALL} !== {m1, 1'b0}) begin
         n_bad++;
         $display("FAIL mul_result a=%h b=%h: got %h stall=%b, want %h stall=0", a, b, obs1, STALL, m1);
      end
      n_cmp++;
      if (stall_cnt != WIDTH || ov_cnt != 1) begin
         n_bad++;
         $display("FAIL mul_timing: got stall_cycles=%0d ov_pulses=%0d, want %0d and 1",
                  stall_cnt, ov_cnt, WIDTH);
      end
      step(held); m1 = op_result(held, 1'b1);
      n_cmp++;
      if (obs1 !== m1) begin
         n_bad++;
         $display("FAIL add_after_mul: got %h, want %h", obs1, m1);
      end
      step(idle_in()); m1 = bubble(m1);
   endtask

   task automatic test_mul();
      logic [31:0] f;
      logic [2:0]  ncv;
      test_mul_case(32'd7, 32'd6, f, ncv);
      n_cmp++;
      if (f !== 32'd42) begin
         n_bad++;
         $display("FAIL mul_7_6: got F=%h, want 2a", f);
      end
      test_mul_case(32'hFFFF_FFFF, 32'd2, f, ncv);
      n_cmp++;
      if ({f, ncv} !== {32'hFFFF_FFFE, 3'b100}) begin
         n_bad++;
         $display("FAIL mul_neg: got F=%h NCV=%b, want FFFFFFFE 100", f, ncv);
      end
      for (int i = 0; i < 6; i++) test_mul_case(pick_val(), pick_val(), f, ncv);
   endtask

   task automatic test_mul_disabled();
      in_t x;
      x = rand_in(1'b0); x.valid = 1'b1; x.fs = 5'b11000; x.a = 32'd7; x.b = 32'd6;
      step(x); m1 = bubble(m1);
      n_cmp++;
      if ({OUT_VALID_2, F_2, STALL_2, Z_2} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL mul_disabled: got ov=%b F=%h stall=%b Z=%b, want ov=1 F=0 stall=0 Z=1",
                  OUT_VALID_2, F_2, STALL_2, Z_2);
      end
      n_cmp++;
      if (obs2 !== m2) begin
         n_bad++;
         $display("FAIL mul_disabled_model: got %h, want %h", obs2, m2);
      end
      x = idle_in(); x.flush = 1'b1;
      step(x); m1 = bubble(m1);
   endtask

   task automatic test_flush();
      in_t mi, held, fx;
      int  ov_cnt;
      mi = rand_in(1'b0); mi.valid = 1'b1; mi.fs = 5'b11000; mi.a = 32'd7; mi.b = 32'd6;
      held = rand_in(1'b0); held.valid = 1'b1; held.fs = 5'b00010; held.rw = 1'b1; held.mw = 1'b1;
      step(mi); m1 = bubble(m1);
      for (int k = 1; k < 10; k++) step(held);
      fx = held; fx.flush = 1'b1;
      step(fx); m1 = bubble(m1);
      n_cmp++;
      if ({STALL, OUT_VALID, RW_out, MW_out} !== 4'b0000 || obs1 !== m1) begin
         n_bad++;
         $display("FAIL flush_mul: got stall=%b ov=%b rw=%b mw=%b out=%h, want 0000 out=%h",
                  STALL, OUT_VALID, RW_out, MW_out, obs1, m1);
      end
      ov_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step(idle_in());
         ov_cnt += int'(OUT_VALID) + int'(STALL);
      end
      n_cmp++;
      if (ov_cnt != 0) begin
         n_bad++;
         $display("FAIL flush_no_result: got %0d valid/stall cycles, want 0", ov_cnt);
      end
      step(held); m1 = op_result(held, 1'b1);
      n_cmp++;
      if (obs1 !== m1) begin
         n_bad++;
         $display("FAIL op_after_flush: got %h, want %h", obs1, m1);
      end
      step(idle_in()); m1 = bubble(m1);
   endtask

   task automatic test_reset_mid_mul();
      in_t mi;
      int  ov_cnt;
      mi = rand_in(1'b0); mi.valid = 1'b1; mi.fs = 5'b11000; mi.a = 32'd7; mi.b = 32'd6;
      mi.rw = 1'b1;
      step(mi);
      for (int k = 1; k < 10; k++) step(rand_in(1'b0));
      RESET = 1'b0;
      #1;
      n_cmp++;
      if ({obs1, STALL} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid_mul: got %h stall=%b, want all zero", obs1, STALL);
      end
      @(posedge CLOCK);
      @(negedge CLOCK);
      RESET = 1'b1;
      m1 = '0;
      m2 = '0;
      ov_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step(idle_in());
         ov_cnt += int'(OUT_VALID) + int'(STALL);
      end
      n_cmp++;
      if (ov_cnt != 0 || obs1 !== m1) begin
         n_bad++;
         $display("FAIL reset_no_partial: got %0d valid/stall cycles out=%h, want 0 and zero",
                  ov_cnt, obs1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_alu();
      test_mul();
      test_mul_disabled();
      test_flush();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
